imm_alu_sequencer: RTL and testbench
====================================

Name: imm_alu_sequencer

Overview:
- Hardwired control sequencer that generates the per-step datapath control strobes for fetch plus the ALU register and ALU immediate instruction classes. The same strobes are used by the existing datapath: pc_out, mar_in, z_in, c_out and the others.
- Replaces hand-sequenced T0–T5 stimulus with a real FSM.
- Adds a memory-ready handshake with timeout, HALT, illegal-opcode trap and a retired-instruction counter.
- Sits between the IR/memory interface and the datapath control inputs.

Parameters:
- OPCODE_W, 5: opcode field width, taken from ir[31:32-OPCODE_W].
- ALU_OP_W, 4: width of alu_op.
- WAIT_MAX, 8: maximum cycles spent in T1 waiting for mem_ready before a fault (valid range ≥1).
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ir  in  32  instruction register contents (valid from T3 onward)
- mem_ready  in  1  memory read data valid in MDR this cycle
- pc_out, mar_in, inc_pc, z_in, z_low_out, pc_in, read, mdr_in, mdr_out, ir_in, gra, grb, grc, r_in, r_out, y_in, c_out  out  1 each  datapath control strobes
- alu_op  out  ALU_OP_W  ALU function select
- step  out  4  current state encoding (debug)
- running  out  1  high unless HALTED or FAULT
- illegal  out  1  one-cycle pulse on an undefined opcode
- fault  out  1  sticky memory-timeout flag
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Moore machine. Every output except retired, fault and illegal is combinational from state and ir. All strobes are 0 outside the states listed here.
- Reset (any cycle, including mid-instruction or while waiting): state = T0, retired = 0, fault = 0, illegal = 0, wait counter = 0. The next cycle begins a clean fetch.
- T0: pc_out, mar_in, inc_pc, z_in, alu_op = ADD. Go to T1.
- T1: z_low_out, pc_in, read, mdr_in. pc_in asserts only on the first T1 cycle; read and mdr_in are held while waiting.
  - mem_ready = 1: go to T2.
  - Otherwise increment the wait counter. When it reaches WAIT_MAX with mem_ready still 0: go to FAULT and set fault.
  - mem_ready = 1 on the same cycle as the counter reaching WAIT_MAX: T2 wins.
- T2: mdr_out, ir_in. Go to T3.
- T3 (decode): opcode = ir top OPCODE_W bits.
  - NOP: retire, go to T0.
  - HALT: retire, go to HALTED.
  - Undefined opcode: illegal = 1 for this cycle, no retire, go to T0.
  - Otherwise assert grb, r_out, y_in and go to T4.
- T4: z_in, alu_op = mapped function.
  - R-type: grc, r_out.
  - I-type: c_out.
  - Go to T5.
- T5: z_low_out, gra, r_in. retired increments (wraps modulo 2^CNT_W). Go to T0.
- HALTED, FAULT: all strobes 0, running = 0. Left only by reset.
- Wait counter clears on entering T1.

Decomposition:
- Shared package seq_pkg:
  - Opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, ADDI 01011, ANDI 01100, ORI 01101, NOP 11010, HALT 11011.
  - ALU function constants: And 0000, Or 0001, Add 0010, Sub 0011 (existing encoding).
  - State encoding: T0–T5 = 1–6, HALTED = 14, FAULT = 15.
  - Opcode-to-alu_op/class decode function.
- Sub-module seq_decode (combinational): maps opcode to {alu_op, is_rtype, is_itype, is_nop, is_halt, is_illegal}.

Test Plan:
- ANDI, mem_ready = 1: ir = 0x61080026 → steps 1,2,3,4,5,6,1. c_out and alu_op = 0000 in T4. gra & r_in in T5. retired 0 → 1.
- Register ADD, mem_ready = 1: ir = 0x19188000 → grc & r_out in T4 with alu_op = 0010, c_out = 0. Six-cycle instruction.
- Memory wait: mem_ready low for 3 cycles in T1 with WAIT_MAX = 8 → T1 lasts 4 cycles, read/mdr_in held. pc_in high only in the first T1 cycle.
- Timeout: mem_ready held 0 → after 8 wait cycles state = 15, fault = 1, running = 0. Reset returns to step 1 with fault = 0.
- Illegal and HALT: opcode 11111 → illegal pulses one cycle at T3, retired unchanged, next step 1. Opcode 11011 → step 14, running = 0, retired + 1, all strobes 0 for 20 cycles.
- Reset mid-instruction: assert reset in T4 → next cycle step 1, retired = 0, no r_in pulse.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the immediate/register ALU control sequencer.
//   - Opcode and ALU function encodings used by the existing datapath.
//   - FSM state encoding (also exported on the debug step output).
//   - Opcode decode function returning ALU function and instruction class.
package seq_pkg;

  localparam int unsigned OpcW = 5;
  localparam int unsigned AluW = 4;

  // Opcodes (top OpcW bits of the instruction register)
  localparam logic [OpcW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpcW-1:0] OpOr   = 5'b00110;
  localparam logic [OpcW-1:0] OpAddi = 5'b01011;
  localparam logic [OpcW-1:0] OpAndi = 5'b01100;
  localparam logic [OpcW-1:0] OpOri  = 5'b01101;
  localparam logic [OpcW-1:0] OpNop  = 5'b11010;
  localparam logic [OpcW-1:0] OpHalt = 5'b11011;

  // ALU function select, existing datapath encoding
  localparam logic [AluW-1:0] AluAnd = 4'b0000;
  localparam logic [AluW-1:0] AluOr  = 4'b0001;
  localparam logic [AluW-1:0] AluAdd = 4'b0010;
  localparam logic [AluW-1:0] AluSub = 4'b0011;

  typedef enum logic [3:0] {
    StT0     = 4'd1,
    StT1     = 4'd2,
    StT2     = 4'd3,
    StT3     = 4'd4,
    StT4     = 4'd5,
    StT5     = 4'd6,
    StHalted = 4'd14,
    StFault  = 4'd15
  } state_e;

  typedef struct packed {
    logic [AluW-1:0] alu_op;
    logic            is_rtype;
    logic            is_itype;
    logic            is_nop;
    logic            is_halt;
    logic            is_illegal;
  } dec_t;

  function automatic dec_t decode_opcode(logic [OpcW-1:0] opc);
    dec_t d;
    d = '0;
    case (opc)
      OpAdd:   begin d.alu_op = AluAdd; d.is_rtype = 1'b1; end
      OpSub:   begin d.alu_op = AluSub; d.is_rtype = 1'b1; end
      OpAnd:   begin d.alu_op = AluAnd; d.is_rtype = 1'b1; end
      OpOr:    begin d.alu_op = AluOr;  d.is_rtype = 1'b1; end
      OpAddi:  begin d.alu_op = AluAdd; d.is_itype = 1'b1; end
      OpAndi:  begin d.alu_op = AluAnd; d.is_itype = 1'b1; end
      OpOri:   begin d.alu_op = AluOr;  d.is_itype = 1'b1; end
      OpNop:   d.is_nop  = 1'b1;
      OpHalt:  d.is_halt = 1'b1;
      default: d.is_illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder.
//   opcode     : instruction opcode field
//   alu_op     : ALU function for ALU-class instructions (0 otherwise)
//   is_rtype   : register-register ALU instruction
//   is_itype   : register-immediate ALU instruction
//   is_nop     : NOP
//   is_halt    : HALT
//   is_illegal : undefined opcode
module seq_decode #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                is_rtype,
  output logic                is_itype,
  output logic                is_nop,
  output logic                is_halt,
  output logic                is_illegal
);
  import seq_pkg::*;

  dec_t dec;

  assign dec        = decode_opcode(OpcW'(opcode));
  assign alu_op     = ALU_OP_W'(dec.alu_op);
  assign is_rtype   = dec.is_rtype;
  assign is_itype   = dec.is_itype;
  assign is_nop     = dec.is_nop;
  assign is_halt    = dec.is_halt;
  assign is_illegal = dec.is_illegal;

endmodule

// File: rtl/imm_alu_sequencer.sv
// Hardwired control sequencer for fetch plus ALU register / ALU immediate instructions.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ir                  : instruction register (opcode valid from T3)
//   mem_ready           : memory read data valid in MDR this cycle
//   pc_out .. c_out     : datapath control strobes (Moore, from state and ir)
//   alu_op              : ALU function select
//   step                : current state encoding (debug)
//   running             : low once HALTED or FAULT
//   illegal             : high during T3 of an undefined opcode
//   fault               : sticky memory-timeout flag
//   retired             : completed-instruction counter (wraps)
module imm_alu_sequencer #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                z_in,
  output logic                z_low_out,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                r_in,
  output logic                r_out,
  output logic                y_in,
  output logic                c_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          step,
  output logic                running,
  output logic                illegal,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);
  import seq_pkg::*;

  localparam int unsigned      WaitW     = $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(WAIT_MAX);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d, wait_inc;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [OPCODE_W-1:0] opcode;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_rtype, dec_itype, dec_nop, dec_halt, dec_illegal;
  logic                unused_ir;

  assign opcode    = ir[31 -: OPCODE_W];
  assign unused_ir = ^ir[31-OPCODE_W:0];

  seq_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode     (opcode),
    .alu_op     (dec_alu_op),
    .is_rtype   (dec_rtype),
    .is_itype   (dec_itype),
    .is_nop     (dec_nop),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign wait_inc = wait_q + WaitW'(1);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fault_d   = fault_q;
    retired_d = retired_q;

    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    z_in      = 1'b0;
    z_low_out = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    r_in      = 1'b0;
    r_out     = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    alu_op    = '0;
    illegal   = 1'b0;

    unique case (state_q)
      StT0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        alu_op  = ALU_OP_W'(AluAdd);
        wait_d  = '0;
        state_d = StT1;
      end
      StT1: begin
        z_low_out = 1'b1;
        read      = 1'b1;
        mdr_in    = 1'b1;
        // Counter is zero only on the first T1 cycle, so PC loads once.
        pc_in     = (wait_q == '0);
        if (mem_ready) begin
          state_d = StT2;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitLimit) begin
            state_d = StFault;
            fault_d = 1'b1;
          end
        end
      end
      StT2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (dec_nop) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = StT0;
        end else if (dec_halt) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = StHalted;
        end else if (dec_illegal) begin
          illegal = 1'b1;
          state_d = StT0;
        end else begin
          grb     = 1'b1;
          r_out   = 1'b1;
          y_in    = 1'b1;
          state_d = StT4;
        end
      end
      StT4: begin
        z_in   = 1'b1;
        alu_op = dec_alu_op;
        if (dec_rtype) begin
          grc   = 1'b1;
          r_out = 1'b1;
        end
        if (dec_itype) begin
          c_out = 1'b1;
        end
        state_d = StT5;
      end
      StT5: begin
        z_low_out = 1'b1;
        gra       = 1'b1;
        r_in      = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StT0;
      end
      StHalted: state_d = StHalted;
      StFault:  state_d = StFault;
      // Unused encodings recover into a clean fetch.
      default:  state_d = StT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StT0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign step    = state_q;
  assign running = (state_q != StHalted) && (state_q != StFault);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
module tb_imm_alu_sequencer;

  // Strobe vector order: pc_out mar_in inc_pc z_in z_low_out pc_in read mdr_in
  //                      mdr_out ir_in gra grb grc r_in r_out y_in c_out
  localparam logic [16:0] ExpT0      = 17'b1_1_1_1_0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] ExpT1First = 17'b0_0_0_0_1_1_1_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] ExpT1Wait  = 17'b0_0_0_0_1_0_1_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] ExpT2      = 17'b0_0_0_0_0_0_0_0_1_1_0_0_0_0_0_0_0;
  localparam logic [16:0] ExpT3      = 17'b0_0_0_0_0_0_0_0_0_0_0_1_0_0_1_1_0;
  localparam logic [16:0] ExpT4I     = 17'b0_0_0_1_0_0_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] ExpT4R     = 17'b0_0_0_1_0_0_0_0_0_0_0_0_1_0_1_0_0;
  localparam logic [16:0] ExpT5      = 17'b0_0_0_0_1_0_0_0_0_0_1_0_0_1_0_0_0;
  localparam logic [16:0] ExpNone    = 17'b0;

  localparam logic [31:0] IrAndi = 32'h6108_0026;
  localparam logic [31:0] IrAdd  = 32'h1918_8000;
  localparam logic [31:0] IrBad  = 32'hF800_0000;
  localparam logic [31:0] IrNop  = 32'hD000_0000;
  localparam logic [31:0] IrHalt = 32'hD800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b1;
  logic pc_out, mar_in, inc_pc, z_in, z_low_out, pc_in, read, mdr_in, mdr_out, ir_in;
  logic gra, grb, grc, r_in, r_out, y_in, c_out;
  logic [3:0]  alu_op;
  logic [3:0]  step;
  logic        running, illegal, fault;
  logic [15:0] retired;
  logic [16:0] strobes;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_retired = '0;

  assign strobes = {pc_out, mar_in, inc_pc, z_in, z_low_out, pc_in, read, mdr_in,
                    mdr_out, ir_in, gra, grb, grc, r_in, r_out, y_in, c_out};

  always #5 clk = ~clk;

  imm_alu_sequencer #(
    .OPCODE_W (5),
    .ALU_OP_W (4),
    .WAIT_MAX (8),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .mar_in    (mar_in),
    .inc_pc    (inc_pc),
    .z_in      (z_in),
    .z_low_out (z_low_out),
    .pc_in     (pc_in),
    .read      (read),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .r_in      (r_in),
    .r_out     (r_out),
    .y_in      (y_in),
    .c_out     (c_out),
    .alu_op    (alu_op),
    .step      (step),
    .running   (running),
    .illegal   (illegal),
    .fault     (fault),
    .retired   (retired)
  );

  // Leaves the bench at a falling edge with the DUT in T0.
  task automatic test_reset();
    reset = 1'b1;
    ir = '0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (step !== 4'd1) begin
      n_fail++; $display("FAIL reset_step: got %0d expected 1", step);
    end
    n_checks++;
    if (retired !== 16'd0 || fault !== 1'b0 || illegal !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: retired=%0d fault=%b illegal=%b running=%b expected 0,0,0,1",
               retired, fault, illegal, running);
    end
    n_checks++;
    if (strobes !== ExpT0 || alu_op !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_t0_strobes: got %b alu=%b expected %b alu=0010", strobes, alu_op, ExpT0);
    end
    reset = 1'b0;
    exp_retired = '0;
  endtask

  task automatic test_andi();
    logic [3:0]  e_step [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    logic [16:0] e_str  [7] = '{ExpT0, ExpT1First, ExpT2, ExpT3, ExpT4I, ExpT5, ExpT0};
    logic [3:0]  e_alu  [7] = '{4'b0010, 4'b0, 4'b0, 4'b0, 4'b0000, 4'b0, 4'b0010};
    ir = IrAndi;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (step !== e_step[i] || strobes !== e_str[i] || alu_op !== e_alu[i]) begin
        n_fail++;
        $display("FAIL andi_cycle%0d: step=%0d str=%b alu=%b expected step=%0d str=%b alu=%b",
                 i, step, strobes, alu_op, e_step[i], e_str[i], e_alu[i]);
      end
      if (i == 5) begin
        n_checks++;
        if (retired !== exp_retired) begin
          n_fail++; $display("FAIL andi_retired_t5: got %0d expected %0d", retired, exp_retired);
        end
      end
    end
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL andi_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_add();
    logic [3:0]  e_step [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    logic [16:0] e_str  [7] = '{ExpT0, ExpT1First, ExpT2, ExpT3, ExpT4R, ExpT5, ExpT0};
    logic [3:0]  e_alu  [7] = '{4'b0010, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0, 4'b0010};
    ir = IrAdd;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (step !== e_step[i] || strobes !== e_str[i] || alu_op !== e_alu[i]) begin
        n_fail++;
        $display("FAIL add_cycle%0d: step=%0d str=%b alu=%b expected step=%0d str=%b alu=%b",
                 i, step, strobes, alu_op, e_step[i], e_str[i], e_alu[i]);
      end
    end
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL add_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  // mem_ready sampled low at the end of three T1 cycles, high on the fourth.
  task automatic test_mem_wait();
    logic [3:0] e_tail [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    ir = IrAndi;
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (step !== 4'd2 || strobes !== ((c == 1) ? ExpT1First : ExpT1Wait)) begin
        n_fail++;
        $display("FAIL wait_t1_cycle%0d: step=%0d str=%b expected step=2 str=%b", c, step,
                 strobes, (c == 1) ? ExpT1First : ExpT1Wait);
      end
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (step !== e_tail[i]) begin
        n_fail++; $display("FAIL wait_tail%0d: step=%0d expected %0d", i, step, e_tail[i]);
      end
    end
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (retired !== exp_retired || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_retired: retired=%0d fault=%b expected %0d,0", retired, fault,
               exp_retired);
    end
  endtask

  task automatic test_illegal();
    ir = IrBad;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (step !== 4'd4 || illegal !== 1'b1 || strobes !== ExpNone) begin
      n_fail++;
      $display("FAIL illegal_t3: step=%0d illegal=%b str=%b expected 4,1,%b", step, illegal,
               strobes, ExpNone);
    end
    @(negedge clk);
    n_checks++;
    if (step !== 4'd1 || illegal !== 1'b0 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL illegal_after: step=%0d illegal=%b retired=%0d expected 1,0,%0d", step,
               illegal, retired, exp_retired);
    end
  endtask

  task automatic test_nop();
    ir = IrNop;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (step !== 4'd4 || illegal !== 1'b0 || strobes !== ExpNone) begin
      n_fail++;
      $display("FAIL nop_t3: step=%0d illegal=%b str=%b expected 4,0,%b", step, illegal,
               strobes, ExpNone);
    end
    @(negedge clk);
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (step !== 4'd1 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL nop_after: step=%0d retired=%0d expected 1,%0d", step, retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid();
    ir = IrAndi;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (step !== 4'd5) begin
      n_fail++; $display("FAIL midreset_t4: step=%0d expected 5", step);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_retired = '0;
    n_checks++;
    if (step !== 4'd1 || retired !== exp_retired || r_in !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: step=%0d retired=%0d r_in=%b expected 1,0,0", step, retired,
               r_in);
    end
    @(negedge clk);
    n_checks++;
    if (step !== 4'd2 || strobes !== ExpT1First) begin
      n_fail++;
      $display("FAIL midreset_fetch: step=%0d str=%b expected 2,%b", step, strobes, ExpT1First);
    end
    // Finish the fetch so the next test starts from T0.
    repeat (5) @(negedge clk);
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (step !== 4'd1 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL midreset_complete: step=%0d retired=%0d expected 1,%0d", step, retired,
               exp_retired);
    end
  endtask

  task automatic test_timeout();
    ir = IrAndi;
    mem_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (step !== 4'd2 || fault !== 1'b0 || running !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: step=%0d fault=%b running=%b expected 2,0,1", c, step,
                 fault, running);
      end
    end
    @(negedge clk);
    n_checks++;
    if (step !== 4'd15 || fault !== 1'b1 || running !== 1'b0 || strobes !== ExpNone) begin
      n_fail++;
      $display("FAIL timeout_fault: step=%0d fault=%b running=%b str=%b expected 15,1,0,0", step,
               fault, running, strobes);
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (step !== 4'd15 || fault !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: step=%0d fault=%b expected 15,1", step, fault);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_retired = '0;
    n_checks++;
    if (step !== 4'd1 || fault !== 1'b0 || running !== 1'b1 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL timeout_reset: step=%0d fault=%b running=%b retired=%0d expected 1,0,1,0",
               step, fault, running, retired);
    end
  endtask

  task automatic test_halt();
    ir = IrHalt;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (step !== 4'd14 || running !== 1'b0 || retired !== exp_retired) begin
      n_fail++;
      $display("FAIL halt_enter: step=%0d running=%b retired=%0d expected 14,0,%0d", step,
               running, retired, exp_retired);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (step !== 4'd14 || strobes !== ExpNone || alu_op !== 4'b0 || retired !== exp_retired) begin
        n_fail++;
        $display("FAIL halt_hold%0d: step=%0d str=%b alu=%b retired=%0d expected 14,0,0,%0d", c,
                 step, strobes, alu_op, retired, exp_retired);
      end
    end
  endtask

  initial begin
    test_reset();
    test_andi();
    test_add();
    test_mem_wait();
    test_illegal();
    test_nop();
    test_reset_mid();
    test_timeout();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
